// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter for up to 16 masters: round-robin or fixed priority selection,
// grant held across fixed-length bursts, undefined-length bursts and locked sequences.
module ahb_arbiter_rr #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned MASTER_W       = 4,
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hrst,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MASTER_W-1:0]    hmaster,
    output logic                   hmastlock
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam logic [2:0] BU_INCR   = 3'd1;

    localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       winner;
    logic                   found;
    logic                   hold;
    logic [NUM_MASTERS-1:0] win_grant;

    // Encode the one-hot grant into the owning master index.
    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant[i]) begin
                owner = IDX_W'(i);
            end
        end
    end

    // Beats remaining after the transfer accepted at this edge.
    always_comb begin
        cnt_n = '0;
        case (htrans)
            TR_NONSEQ: begin
                case (hburst)
                    3'd2, 3'd3: cnt_n = CNT_W'(3);
                    3'd4, 3'd5: cnt_n = CNT_W'(7);
                    3'd6, 3'd7: cnt_n = CNT_W'(15);
                    default:    cnt_n = '0;
                endcase
            end
            TR_SEQ:  cnt_n = (cnt == '0) ? '0 : cnt - CNT_W'(1);
            TR_BUSY: cnt_n = cnt;
            default: cnt_n = '0;
        endcase
    end

    // An undefined-length burst keeps the bus for as long as its owner keeps requesting.
    always_comb begin
        hold = (cnt_n != '0)
            || hlock[owner]
            || ((hburst == BU_INCR) && (htrans != TR_IDLE) && hbusreq[owner]);
    end

    // Round-robin searches upward from the slot after the last winner; fixed priority from 0.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (PRIORITY_MODE != 0) begin
                idx = i;
            end else begin
                idx = (32'(rr_ptr) + i + 1) % NUM_MASTERS;
            end
            if (!found && hbusreq[IDX_W'(idx)]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
        win_grant = found ? (NUM_MASTERS'(1) << winner) : PARK_GRANT;
    end

    // State only advances on accepted transfers; reset wins regardless of hready.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            hgrant    <= PARK_GRANT;
            hmaster   <= MASTER_W'(DEFAULT_MASTER);
            hmastlock <= 1'b0;
            cnt       <= '0;
            rr_ptr    <= IDX_W'(DEFAULT_MASTER);
        end else if (hready) begin
            cnt       <= cnt_n;
            hmaster   <= MASTER_W'(owner);
            hmastlock <= hlock[owner];
            if (!hold) begin
                hgrant <= win_grant;
                if (found && (PRIORITY_MODE == 0)) begin
                    rr_ptr <= winner;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed bench for ahb_arbiter_rr: a round-robin instance (park on master 2) and a
// fixed-priority instance (park on master 0) share the same bus stimulus.
module tb_ahb_arbiter_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned MW = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;

    logic          hclk = 1'b0;
    logic          hrst;
    logic [N-1:0]  hbusreq;
    logic [N-1:0]  hlock;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic          hready;

    logic [N-1:0]  rr_hgrant;
    logic [MW-1:0] rr_hmaster;
    logic          rr_hmastlock;
    logic [N-1:0]  fp_hgrant;
    logic [MW-1:0] fp_hmaster;
    logic          fp_hmastlock;

    int errors = 0;
    int checks = 0;

    always #5 hclk = ~hclk;

    ahb_arbiter_rr #(.NUM_MASTERS(N), .MASTER_W(MW), .PRIORITY_MODE(0), .DEFAULT_MASTER(2)) dut_rr (
        .hclk(hclk), .hrst(hrst), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
        .hburst(hburst), .hready(hready), .hgrant(rr_hgrant), .hmaster(rr_hmaster),
        .hmastlock(rr_hmastlock)
    );

    ahb_arbiter_rr #(.NUM_MASTERS(N), .MASTER_W(MW), .PRIORITY_MODE(1), .DEFAULT_MASTER(0)) dut_fp (
        .hclk(hclk), .hrst(hrst), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
        .hburst(hburst), .hready(hready), .hgrant(fp_hgrant), .hmaster(fp_hmaster),
        .hmastlock(fp_hmastlock)
    );

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck,
                         input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        hbusreq = req;
        hlock   = lck;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hrst = 1'b1;
        drive(4'h0, 4'h0, IDLE, SINGLE, 1'b0);
        tick();
        tick();
        checks++;
        if ({rr_hgrant, rr_hmaster, rr_hmastlock} !== {4'h4, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL reset_rr: got g=%h m=%0d l=%b expected g=4 m=2 l=0", rr_hgrant, rr_hmaster, rr_hmastlock);
        end
        checks++;
        if ({fp_hgrant, fp_hmaster, fp_hmastlock} !== {4'h1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_fp: got g=%h m=%0d l=%b expected g=1 m=0 l=0", fp_hgrant, fp_hmaster, fp_hmastlock);
        end
        hrst = 1'b0;
        drive(4'h0, 4'h0, IDLE, SINGLE, 1'b1);
        repeat (3) tick();
        checks++;
        if ({rr_hgrant, rr_hmaster, rr_hmastlock} !== {4'h4, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL idle_park: got g=%h m=%0d l=%b expected g=4 m=2 l=0", rr_hgrant, rr_hmaster, rr_hmastlock);
        end
    endtask

    task automatic test_rr_fairness();
        logic [N-1:0]  exp_g [6];
        logic [MW-1:0] exp_m [6];
        exp_g = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        exp_m = '{4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
        drive(4'hF, 4'h0, NONSEQ, SINGLE, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({rr_hgrant, rr_hmaster} !== {exp_g[i], exp_m[i]}) begin
                errors++;
                $display("FAIL rr_cycle[%0d]: got g=%h m=%0d expected g=%h m=%0d", i, rr_hgrant, rr_hmaster, exp_g[i], exp_m[i]);
            end
        end
        checks++;
        if (fp_hgrant !== 4'h1) begin
            errors++;
            $display("FAIL fp_all_req: got g=%h expected g=1", fp_hgrant);
        end
    endtask

    task automatic test_burst_hold();
        drive(4'h2, 4'h0, IDLE, SINGLE, 1'b1);
        tick();
        checks++;
        if (rr_hgrant !== 4'h2) begin
            errors++;
            $display("FAIL burst_grant_m1: got g=%h expected g=2", rr_hgrant);
        end
        drive(4'hA, 4'h0, NONSEQ, INCR4, 1'b1);
        tick();
        checks++;
        if ({rr_hgrant, rr_hmaster} !== {4'h2, 4'd1}) begin
            errors++;
            $display("FAIL burst_beat1: got g=%h m=%0d expected g=2 m=1", rr_hgrant, rr_hmaster);
        end
        htrans = SEQ;
        for (int i = 2; i <= 3; i++) begin
            tick();
            checks++;
            if (rr_hgrant !== 4'h2) begin
                errors++;
                $display("FAIL burst_beat%0d: got g=%h expected g=2", i, rr_hgrant);
            end
        end
        tick();
        checks++;
        if ({rr_hgrant, rr_hmaster} !== {4'h8, 4'd1}) begin
            errors++;
            $display("FAIL burst_handover: got g=%h m=%0d expected g=8 m=1", rr_hgrant, rr_hmaster);
        end
        drive(4'h8, 4'h0, NONSEQ, SINGLE, 1'b1);
        tick();
        checks++;
        if ({rr_hgrant, rr_hmaster} !== {4'h8, 4'd3}) begin
            errors++;
            $display("FAIL burst_hmaster: got g=%h m=%0d expected g=8 m=3", rr_hgrant, rr_hmaster);
        end
    endtask

    task automatic test_stall_early_term();
        drive(4'h9, 4'h0, NONSEQ, INCR8, 1'b1);
        tick();
        htrans = SEQ;
        repeat (4) tick();
        checks++;
        if (rr_hgrant !== 4'h8) begin
            errors++;
            $display("FAIL incr8_beat5: got g=%h expected g=8", rr_hgrant);
        end
        drive(4'h1, 4'h0, IDLE, SINGLE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rr_hgrant, rr_hmaster, rr_hmastlock} !== {4'h8, 4'd3, 1'b0}) begin
                errors++;
                $display("FAIL stall[%0d]: got g=%h m=%0d l=%b expected g=8 m=3 l=0", i, rr_hgrant, rr_hmaster, rr_hmastlock);
            end
        end
        drive(4'h9, 4'h0, SEQ, INCR8, 1'b1);
        tick();
        checks++;
        if (rr_hgrant !== 4'h8) begin
            errors++;
            $display("FAIL incr8_beat6: got g=%h expected g=8", rr_hgrant);
        end
        htrans = IDLE;
        tick();
        checks++;
        if ({rr_hgrant, rr_hmaster} !== {4'h1, 4'd3}) begin
            errors++;
            $display("FAIL early_term: got g=%h m=%0d expected g=1 m=3", rr_hgrant, rr_hmaster);
        end
    endtask

    task automatic test_lock();
        drive(4'h4, 4'h4, IDLE, SINGLE, 1'b1);
        tick();
        checks++;
        if ({rr_hgrant, rr_hmaster, rr_hmastlock} !== {4'h4, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL lock_grant_m2: got g=%h m=%0d l=%b expected g=4 m=0 l=0", rr_hgrant, rr_hmaster, rr_hmastlock);
        end
        drive(4'h5, 4'h4, NONSEQ, SINGLE, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({rr_hgrant, rr_hmaster, rr_hmastlock} !== {4'h4, 4'd2, 1'b1}) begin
                errors++;
                $display("FAIL lock_held[%0d]: got g=%h m=%0d l=%b expected g=4 m=2 l=1", i, rr_hgrant, rr_hmaster, rr_hmastlock);
            end
        end
        drive(4'h1, 4'h0, IDLE, SINGLE, 1'b1);
        tick();
        checks++;
        if ({rr_hgrant, rr_hmaster, rr_hmastlock} !== {4'h1, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL lock_release: got g=%h m=%0d l=%b expected g=1 m=2 l=0", rr_hgrant, rr_hmaster, rr_hmastlock);
        end
    endtask

    task automatic test_incr_hold();
        drive(4'h3, 4'h0, NONSEQ, INCR, 1'b1);
        tick();
        checks++;
        if ({rr_hgrant, rr_hmaster} !== {4'h1, 4'd0}) begin
            errors++;
            $display("FAIL incr_hold_nonseq: got g=%h m=%0d expected g=1 m=0", rr_hgrant, rr_hmaster);
        end
        htrans = SEQ;
        tick();
        checks++;
        if (rr_hgrant !== 4'h1) begin
            errors++;
            $display("FAIL incr_hold_seq: got g=%h expected g=1", rr_hgrant);
        end
        drive(4'h2, 4'h0, SEQ, INCR, 1'b1);
        tick();
        checks++;
        if (rr_hgrant !== 4'h2) begin
            errors++;
            $display("FAIL incr_release: got g=%h expected g=2", rr_hgrant);
        end
    endtask

    task automatic test_fixed_priority();
        hrst = 1'b1;
        drive(4'h0, 4'h0, IDLE, SINGLE, 1'b1);
        tick();
        hrst = 1'b0;
        drive(4'hA, 4'h0, IDLE, SINGLE, 1'b1);
        tick();
        checks++;
        if ({fp_hgrant, fp_hmaster} !== {4'h2, 4'd0}) begin
            errors++;
            $display("FAIL fp_req_A: got g=%h m=%0d expected g=2 m=0", fp_hgrant, fp_hmaster);
        end
        drive(4'h8, 4'h0, IDLE, SINGLE, 1'b1);
        tick();
        checks++;
        if ({fp_hgrant, fp_hmaster} !== {4'h8, 4'd1}) begin
            errors++;
            $display("FAIL fp_req_8: got g=%h m=%0d expected g=8 m=1", fp_hgrant, fp_hmaster);
        end
        drive(4'h9, 4'h0, NONSEQ, INCR4, 1'b1);
        tick();
        htrans = SEQ;
        tick();
        checks++;
        if (fp_hgrant !== 4'h8) begin
            errors++;
            $display("FAIL fp_burst_hold: got g=%h expected g=8", fp_hgrant);
        end
        hrst = 1'b1;
        drive(4'h9, 4'h0, SEQ, INCR4, 1'b0);
        tick();
        checks++;
        if ({fp_hgrant, fp_hmaster, fp_hmastlock} !== {4'h1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL fp_mid_burst_reset: got g=%h m=%0d l=%b expected g=1 m=0 l=0", fp_hgrant, fp_hmaster, fp_hmastlock);
        end
        checks++;
        if ({rr_hgrant, rr_hmaster, rr_hmastlock} !== {4'h4, 4'd2, 1'b0}) begin
            errors++;
            $display("FAIL rr_mid_burst_reset: got g=%h m=%0d l=%b expected g=4 m=2 l=0", rr_hgrant, rr_hmaster, rr_hmastlock);
        end
        hrst = 1'b0;
        drive(4'h8, 4'h0, SEQ, INCR4, 1'b1);
        tick();
        checks++;
        if (fp_hgrant !== 4'h8) begin
            errors++;
            $display("FAIL fp_hold_discarded: got g=%h expected g=8", fp_hgrant);
        end
    endtask

    initial begin
        hrst = 1'b1;
        drive(4'h0, 4'h0, IDLE, SINGLE, 1'b0);
        test_reset();
        test_rr_fairness();
        test_burst_hold();
        test_stall_early_term();
        test_lock();
        test_incr_hold();
        test_fixed_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
